// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared constants, types and decode helper for the control unit
//
// Purpose : op-type constants, ARM condition codes, instruction field positions,
//           hazard FSM state encoding, the decoded stage-register struct and the
//           field decoder used by pipelined_control_unit.
// Ports   : none (package)
package control_pkg;

    localparam logic [1:0] OP_DP = 2'b00;
    localparam logic [1:0] OP_LS = 2'b01;
    localparam logic [1:0] OP_BR = 2'b10;
    localparam logic [1:0] OP_CP = 2'b11;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    localparam int COND_LSB = 28;
    localparam int OP_LSB   = 26;
    localparam int I_BIT    = 25;
    localparam int LINK_BIT = 24;
    localparam int OPC_LSB  = 21;
    localparam int B_BIT    = 22;
    localparam int S_BIT    = 20;
    localparam int L_BIT    = 20;
    localparam int RN_LSB   = 16;
    localparam int RD_LSB   = 12;
    localparam int RM_LSB   = 0;

    typedef enum logic {
        HZ_IDLE      = 1'b0,
        HZ_LOAD_PEND = 1'b1
    } haz_state_e;

    typedef struct packed {
        logic       rwe;
        logic       mwe;
        logic       m2r;
        logic       src;
        logic       status;
        logic [3:0] alu_op;
        logic       pcsel;
        logic       link;
        logic       mem_byte;
        logic       cond_pass;
        logic [3:0] rd;
    } ctrl_t;

    // Field decode of a 32-bit ARM-style word given its condition result.
    // A failed condition suppresses every architectural side effect but keeps
    // the informational fields so execute can still see what was skipped.
    function automatic ctrl_t decode_instr(input logic [31:0] ins, input logic pass);
        ctrl_t c;
        c           = '0;
        c.rd        = ins[RD_LSB +: 4];
        c.cond_pass = pass;
        case (ins[OP_LSB +: 2])
            OP_DP: begin
                c.rwe    = 1'b1;
                c.alu_op = ins[OPC_LSB +: 4];
                c.status = ins[S_BIT];
                c.src    = ins[I_BIT];
            end
            OP_LS: begin
                c.src      = 1'b1;
                c.mem_byte = ins[B_BIT];
                if (ins[L_BIT]) begin
                    c.rwe = 1'b1;
                    c.m2r = 1'b1;
                end else begin
                    c.mwe = 1'b1;
                end
            end
            OP_BR: begin
                c.pcsel  = 1'b1;
                c.alu_op = ins[OPC_LSB +: 4];
                c.link   = ins[LINK_BIT];
            end
            default: ;
        endcase
        if (!pass) begin
            c.rwe    = 1'b0;
            c.mwe    = 1'b0;
            c.status = 1'b0;
            c.pcsel  = 1'b0;
            c.link   = 1'b0;
        end
        // The all-zero word is a true NOP, not an EQ data-processing op.
        if (ins == 32'h0) begin
            c = '0;
        end
        return c;
    endfunction

endpackage

// File: rtl/cond_evaluator.sv
// rtl/cond_evaluator.sv - combinational ARM condition-code evaluation
//
// Purpose : decides whether an instruction's condition field passes for the
//           current flags.
// Ports   : cond [3:0] in  - condition field
//           nzcv [3:0] in  - flags {N,Z,C,V}
//           pass       out - condition true
module cond_evaluator
    import control_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - registered instruction decoder with load-use interlock
//
// Purpose : accepts one instruction per in_valid/in_ready handshake, decodes it with
//           condition evaluation into the decode/execute stage register, and refuses
//           instructions that read a register still being loaded.
// Ports   : clk, rst_n (async active-low), flush
//           in_valid/in_ready/instruction/nzcv - fetch side
//           out_valid/out_ready                - execute side
//           reg_write_enable, mem_write_enable, mem_to_reg_select, alu_source_select,
//           status_bit, alu_operation, pc_source_select, branch_link, mem_byte,
//           cond_pass, rd_addr                 - registered decoded controls
module pipelined_control_unit
    import control_pkg::*;
#(
    parameter int INSTR_W  = 32,
    parameter int ALU_OP_W = 4,
    parameter int REG_AW   = 4,
    parameter int HAZ_CYC  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic [3:0]          nzcv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                reg_write_enable,
    output logic                mem_write_enable,
    output logic                mem_to_reg_select,
    output logic                alu_source_select,
    output logic                status_bit,
    output logic [ALU_OP_W-1:0] alu_operation,
    output logic                pc_source_select,
    output logic                branch_link,
    output logic                mem_byte,
    output logic                cond_pass,
    output logic [REG_AW-1:0]   rd_addr
);

    localparam logic [2:0] HAZ_INIT = 3'(HAZ_CYC);

    logic [31:0] ins;
    logic        pass;
    ctrl_t       dec;
    ctrl_t       stage;
    haz_state_e  state;
    logic [2:0]  hazard_cnt;
    logic [3:0]  ld_rd;
    logic        hazard_block;
    logic        accept;
    logic        load_accept;

    assign ins = instruction[31:0];

    cond_evaluator u_cond (
        .cond (ins[COND_LSB +: 4]),
        .nzcv (nzcv),
        .pass (pass)
    );

    assign dec = decode_instr(ins, pass);

    // Interlock looks at the raw register fields of the word on the bus,
    // regardless of its condition: a skipped reader costs one bubble at most.
    always_comb begin
        hazard_block = 1'b0;
        if (state == HZ_LOAD_PEND) begin
            if ((ins[OP_LSB +: 2] == OP_DP || ins[OP_LSB +: 2] == OP_LS) &&
                ins[RN_LSB +: 4] == ld_rd) begin
                hazard_block = 1'b1;
            end
            if (ins[OP_LSB +: 2] == OP_DP && !ins[I_BIT] && ins[RM_LSB +: 4] == ld_rd) begin
                hazard_block = 1'b1;
            end
        end
    end

    assign in_ready    = rst_n & ~flush & (~out_valid | out_ready) & ~hazard_block;
    assign accept      = in_valid & in_ready;
    // Only a load that will actually write its destination creates a dependency.
    assign load_accept = accept & dec.rwe & dec.m2r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HZ_IDLE;
            hazard_cnt <= '0;
            ld_rd      <= '0;
        end else if (flush) begin
            state      <= HZ_IDLE;
            hazard_cnt <= '0;
        end else if (load_accept) begin
            state      <= HZ_LOAD_PEND;
            ld_rd      <= ins[RD_LSB +: 4];
            hazard_cnt <= HAZ_INIT;
        end else if (state == HZ_LOAD_PEND) begin
            if (hazard_cnt <= 3'd1) begin
                state      <= HZ_IDLE;
                hazard_cnt <= '0;
            end else begin
                hazard_cnt <= hazard_cnt - 3'd1;
            end
        end
    end

    // Stage register clears when it empties so downstream never sees stale controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            stage     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            stage     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            stage     <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            stage     <= '0;
        end
    end

    assign reg_write_enable  = stage.rwe;
    assign mem_write_enable  = stage.mwe;
    assign mem_to_reg_select = stage.m2r;
    assign alu_source_select = stage.src;
    assign status_bit        = stage.status;
    assign alu_operation     = ALU_OP_W'(stage.alu_op);
    assign pc_source_select  = stage.pcsel;
    assign branch_link       = stage.link;
    assign mem_byte          = stage.mem_byte;
    assign cond_pass         = stage.cond_pass;
    assign rd_addr           = REG_AW'(stage.rd);

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - scoreboard bench for pipelined_control_unit
module tb_pipelined_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [3:0]  nzcv;
    logic        out_valid;
    logic        out_ready;
    logic        reg_write_enable;
    logic        mem_write_enable;
    logic        mem_to_reg_select;
    logic        alu_source_select;
    logic        status_bit;
    logic [3:0]  alu_operation;
    logic        pc_source_select;
    logic        branch_link;
    logic        mem_byte;
    logic        cond_pass;
    logic [3:0]  rd_addr;

    int tests = 0;
    int fails = 0;

    logic [16:0] sb[$];
    logic [16:0] cur_exp;
    logic [16:0] obs;
    logic [16:0] drop;
    int          w;

    pipelined_control_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .instruction       (instruction),
        .nzcv              (nzcv),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .reg_write_enable  (reg_write_enable),
        .mem_write_enable  (mem_write_enable),
        .mem_to_reg_select (mem_to_reg_select),
        .alu_source_select (alu_source_select),
        .status_bit        (status_bit),
        .alu_operation     (alu_operation),
        .pc_source_select  (pc_source_select),
        .branch_link       (branch_link),
        .mem_byte          (mem_byte),
        .cond_pass         (cond_pass),
        .rd_addr           (rd_addr)
    );

    always #5 clk = ~clk;

    assign obs = {reg_write_enable, mem_write_enable, mem_to_reg_select, alu_source_select,
                  status_bit, alu_operation, pc_source_select, branch_link, mem_byte,
                  cond_pass, rd_addr};

    function automatic logic [16:0] mk(input logic rwe, input logic mwe, input logic m2r,
                                       input logic src, input logic st, input logic [3:0] alu,
                                       input logic pc, input logic bl, input logic by,
                                       input logic cp, input logic [3:0] rd);
        return {rwe, mwe, m2r, src, st, alu, pc, bl, by, cp, rd};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pop on consumption, then push whatever is being accepted this cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(obs), 32'h1ffff);
            end else begin
                check("decode", 32'(obs), 32'(sb.pop_front()));
            end
        end
        if (rst_n && in_valid && in_ready) begin
            sb.push_back(cur_exp);
        end
    end

    task automatic send(input logic [31:0] ins, input logic [3:0] f, input logic [16:0] e,
                        output int waits);
        bit done;
        in_valid    = 1'b1;
        instruction = ins;
        nzcv        = f;
        cur_exp     = e;
        waits       = 0;
        done        = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 20) begin
                    check("send_timeout", 32'(waits), 32'd0);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [31:0] I_ADDI  = 32'hE2821001;
    localparam logic [31:0] I_ADDEQ = 32'h02821001;
    localparam logic [31:0] I_LDR   = 32'hE5943000;
    localparam logic [31:0] I_LDRNE = 32'h15D43000;
    localparam logic [31:0] I_DEP_N = 32'hE0835006;
    localparam logic [31:0] I_INDEP = 32'hE0875006;
    localparam logic [31:0] I_DEP_M = 32'hE0875003;
    localparam logic [31:0] I_IMM_M = 32'hE2875003;
    localparam logic [31:0] I_STRB  = 32'hE5C43000;
    localparam logic [31:0] I_BL    = 32'hEB000010;
    localparam logic [31:0] I_BLNE  = 32'h1B000010;
    localparam logic [31:0] I_SUBS  = 32'hE0512000;
    localparam logic [31:0] I_SUBNV = 32'hF0512000;
    localparam logic [31:0] I_SUBGE = 32'hA0512000;
    localparam logic [31:0] I_SUBLT = 32'hB0512000;
    localparam logic [31:0] I_CP    = 32'hEC000000;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instruction = 32'h0; nzcv = 4'h0; cur_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_outputs", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic decode, latency and drain
        send(I_ADDI, 4'h0, mk(1,0,0,1,0,4'h4,0,0,0,1,4'd1), w);
        check("latency_valid", 32'(out_valid), 32'd1);
        idle(1);
        check("drain_valid", 32'(out_valid), 32'd0);

        send(I_ADDEQ, 4'b0000, mk(0,0,0,1,0,4'h4,0,0,0,0,4'd1), w);
        send(I_ADDEQ, 4'b0100, mk(1,0,0,1,0,4'h4,0,0,0,1,4'd1), w);
        send(I_STRB,  4'h0,    mk(0,1,0,1,0,4'h0,0,0,1,1,4'd3), w);
        send(I_BL,    4'h0,    mk(0,0,0,0,0,4'h8,1,1,0,1,4'd0), w);
        send(I_BLNE,  4'b0100, mk(0,0,0,0,0,4'h8,0,0,0,0,4'd0), w);
        send(I_SUBNV, 4'h0,    mk(0,0,0,0,0,4'h2,0,0,0,0,4'd2), w);
        send(I_SUBS,  4'h0,    mk(1,0,0,0,1,4'h2,0,0,0,1,4'd2), w);
        send(I_SUBGE, 4'b1000, mk(0,0,0,0,0,4'h2,0,0,0,0,4'd2), w);
        send(I_SUBLT, 4'b1000, mk(1,0,0,0,1,4'h2,0,0,0,1,4'd2), w);
        send(32'h0,   4'hF,    17'h0, w);
        send(I_CP,    4'h0,    mk(0,0,0,0,0,4'h0,0,0,0,1,4'd0), w);

        // Load-use interlock
        send(I_LDR,   4'h0, mk(1,0,1,1,0,4'h0,0,0,0,1,4'd3), w);
        send(I_DEP_N, 4'h0, mk(1,0,0,0,0,4'h4,0,0,0,1,4'd5), w);
        check("haz_rn_wait", 32'(w), 32'd1);
        send(I_LDR,   4'h0, mk(1,0,1,1,0,4'h0,0,0,0,1,4'd3), w);
        send(I_INDEP, 4'h0, mk(1,0,0,0,0,4'h4,0,0,0,1,4'd5), w);
        check("haz_indep_wait", 32'(w), 32'd0);
        send(I_LDR,   4'h0, mk(1,0,1,1,0,4'h0,0,0,0,1,4'd3), w);
        send(I_DEP_M, 4'h0, mk(1,0,0,0,0,4'h4,0,0,0,1,4'd5), w);
        check("haz_rm_wait", 32'(w), 32'd1);
        send(I_LDR,   4'h0, mk(1,0,1,1,0,4'h0,0,0,0,1,4'd3), w);
        send(I_IMM_M, 4'h0, mk(1,0,0,1,0,4'h4,0,0,0,1,4'd5), w);
        check("haz_imm_wait", 32'(w), 32'd0);
        send(I_LDRNE, 4'b0100, mk(0,0,1,1,0,4'h0,0,0,1,0,4'd3), w);
        send(I_DEP_N, 4'b0100, mk(1,0,0,0,0,4'h4,0,0,0,1,4'd5), w);
        check("haz_failed_load_wait", 32'(w), 32'd0);
        idle(2);

        // Back-pressure: stage full for 3 cycles with a new word waiting
        out_ready = 1'b0;
        send(I_ADDI, 4'h0, mk(1,0,0,1,0,4'h4,0,0,0,1,4'd1), w);
        in_valid = 1'b1; instruction = I_SUBS; nzcv = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_hold", 32'(obs), 32'(mk(1,0,0,1,0,4'h4,0,0,0,1,4'd1)));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(I_SUBS, 4'h0, mk(1,0,0,0,1,4'h2,0,0,0,1,4'd2), w);
        check("stall_release_wait", 32'(w), 32'd0);
        idle(2);

        // Flush with a new word offered
        out_ready = 1'b0;
        send(I_BL, 4'h0, mk(0,0,0,0,0,4'h8,1,1,0,1,4'd0), w);
        in_valid = 1'b1; instruction = I_ADDI; flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_outputs", 32'(obs), 32'd0);
        drop = sb.pop_front();
        out_ready = 1'b1;
        send(I_ADDI, 4'h0, mk(1,0,0,1,0,4'h4,0,0,0,1,4'd1), w);
        idle(1);

        // Asynchronous reset with a word in flight
        out_ready = 1'b0;
        send(I_SUBS, 4'h0, mk(1,0,0,0,1,4'h2,0,0,0,1,4'd2), w);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_outputs", 32'(obs), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        drop = sb.pop_front();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(I_BL, 4'h0, mk(0,0,0,0,0,4'h8,1,1,0,1,4'd0), w);
        idle(3);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
